sentinel_key_conditioner: RTL and testbench

Upstream input stage for the Sentinel lock core (tt_um_vaelix_sentinel). It synchronizes the raw ui_in key byte into the clk domain and debounces it. It then presents each settled key byte to the lock core as a held value plus a one-cycle strobe. It also counts aborted settles (glitches) so brute-force dithering of the key pins is observable.

---
 rtl/sentinel_key_conditioner_pkg.sv | 15 +
 rtl/sentinel_key_conditioner_if.sv | 17 +
 rtl/sentinel_key_conditioner_sync_bus.sv | 24 ++
 rtl/sentinel_key_conditioner.sv | 92 +++++++++
 tb/tb_sentinel_key_conditioner.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sentinel_key_conditioner_pkg.sv
// Shared types and constants for the Sentinel lock core input path.
// Also used by the lock core and its formal bind.
package sentinel_pkg;

    localparam int KEY_W = 8;
    localparam logic [KEY_W-1:0] AUTH_KEY      = 8'hB6;
    localparam logic [KEY_W-1:0] VERIFIED_CODE = 8'hC1;

    typedef enum logic [1:0] {IDLE, SETTLING, STABLE} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sentinel_key_conditioner_if.sv
// Key-byte bus between the pin side and the conditioner.
// The master drives the pins and enable; the slave returns the settled key.
interface sentinel_key_if;
    import sentinel_pkg::*;

    logic             ena;
    logic [KEY_W-1:0] ui_in;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_stable;
    logic [7:0]       glitch_cnt;

    modport master (output ena, ui_in,
                    input  key_out, key_valid, key_stable, glitch_cnt);
    modport slave  (input  ena, ui_in,
                    output key_out, key_valid, key_stable, glitch_cnt);
endinterface

// File: rtl/sentinel_key_conditioner_sync_bus.sv
// Multi-flop synchronizer for a byte-wide asynchronous bus.
// Per-bit skew is left for the downstream whole-byte debounce to absorb.
module sentinel_sync_bus
    import sentinel_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int W           = KEY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [SYNC_STAGES-1:0][W-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sentinel_key_conditioner.sv
// Synchronizes and debounces the raw key byte, then presents each settled
// byte as a held value plus a one-cycle strobe; counts aborted settles.
module sentinel_key_conditioner
    import sentinel_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sentinel_key_if.slave   kif
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit               ONE_SHOT   = (DEBOUNCE_CYCLES == 1);

    logic [KEY_W-1:0] sync_out;
    logic [KEY_W-1:0] candidate;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    state_t           state;

    logic do_load, do_glitch, settle_hit, accept;

    sentinel_sync_bus #(.SYNC_STAGES(SYNC_STAGES), .W(KEY_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kif.ui_in),
        .q     (sync_out)
    );

    assign cnt_nxt = cnt + CNT_ONE;

    // A fresh candidate load counts as the first matching cycle, so with a
    // one-cycle debounce the load itself is the accepting edge.
    always_comb begin
        do_load    = 1'b0;
        do_glitch  = 1'b0;
        settle_hit = 1'b0;
        case (state)
            IDLE:     do_load = 1'b1;
            SETTLING: begin
                if (sync_out == candidate) begin
                    settle_hit = (cnt_nxt == CNT_TARGET);
                end else begin
                    do_load   = 1'b1;
                    do_glitch = 1'b1;
                end
            end
            STABLE:   do_load = (sync_out != kif.key_out);
            default:  do_load = 1'b1;
        endcase
        accept = (do_load && ONE_SHOT) || settle_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            candidate      <= '0;
            cnt            <= '0;
            kif.key_out    <= '0;
            kif.key_valid  <= 1'b0;
            kif.key_stable <= 1'b0;
            kif.glitch_cnt <= '0;
        end else begin
            kif.key_valid <= 1'b0;
            if (kif.ena) begin
                if (do_glitch) kif.glitch_cnt <= sat_inc8(kif.glitch_cnt);

                if (do_load) begin
                    candidate <= sync_out;
                    cnt       <= CNT_ONE;
                end else if (state == SETTLING) begin
                    cnt <= cnt_nxt;
                end

                if (accept) begin
                    kif.key_out    <= do_load ? sync_out : candidate;
                    kif.key_valid  <= 1'b1;
                    kif.key_stable <= 1'b1;
                    state          <= STABLE;
                end else if (do_load) begin
                    kif.key_stable <= 1'b0;
                    state          <= SETTLING;
                end
            end
        end
    end

endmodule

// File: tb/tb_sentinel_key_conditioner.sv
// Randomized and directed bench for sentinel_key_conditioner against a
// run-length reference model of the debounce rules.
module tb_sentinel_key_conditioner;
  import sentinel_pkg::*;

  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sentinel_key_if kif();

  sentinel_key_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: pins reach the comparator S edges later; a run of equal
  // enabled samples is accepted when it reaches D samples long.
  logic [7:0] pipe_q[$];
  logic [7:0] win_q[$];
  bit         m_idle;
  bit         m_acc;
  bit         m_valid;
  logic [7:0] m_run_val;
  int         m_run_len;
  logic [7:0] m_key;
  logic [7:0] m_glitch;
  int         strobes;

  task automatic model_reset();
    pipe_q.delete();
    win_q.delete();
    for (int i = 0; i < S; i++) pipe_q.push_back(8'h00);
    m_idle = 1; m_acc = 0; m_valid = 0;
    m_run_val = 8'h00; m_run_len = 0;
    m_key = 8'h00; m_glitch = 8'h00;
  endtask

  task automatic start_run(input logic [7:0] s);
    m_idle = 0; m_run_val = s; m_run_len = 1; m_acc = 0;
    if (m_run_len == D) begin m_acc = 1; m_key = s; m_valid = 1; end
  endtask

  task automatic model_edge(input bit en, input logic [7:0] u);
    logic [7:0] s;
    s = pipe_q.pop_front();
    pipe_q.push_back(u);
    m_valid = 0;
    if (!en) return;
    win_q.push_back(s);
    if (win_q.size() > D) void'(win_q.pop_front());
    if (m_idle) start_run(s);
    else if (s == m_run_val) begin
      if (!m_acc) begin
        m_run_len++;
        if (m_run_len == D) begin m_acc = 1; m_key = s; m_valid = 1; end
      end
    end else begin
      if (!m_acc && m_glitch != 8'hFF) m_glitch = m_glitch + 8'd1;
      start_run(s);
    end
  endtask

  task automatic step();
    bit ok;
    @(posedge clk);
    if (rst_n) model_edge(kif.ena, kif.ui_in);
    #1;
    chk("key_out", kif.key_out, m_key);
    chk("key_valid", kif.key_valid, m_valid);
    chk("key_stable", kif.key_stable, m_acc && !m_idle);
    chk("glitch_cnt", kif.glitch_cnt, m_glitch);
    if (kif.key_valid === 1'b1) begin
      strobes++;
      ok = (win_q.size() == D);
      foreach (win_q[i]) if (win_q[i] != kif.key_out) ok = 0;
      chk("held_window", ok, 1);
    end
  endtask

  initial begin
    int first;
    int n;
    bit hit;
    logic [7:0] v;

    kif.ena = 1'b0;
    kif.ui_in = 8'h00;
    model_reset();
    strobes = 0;
    #12;
    chk("rst_key_out", kif.key_out, 8'h00);
    chk("rst_valid", kif.key_valid, 1'b0);
    chk("rst_stable", kif.key_stable, 1'b0);
    chk("rst_glitch", kif.glitch_cnt, 8'h00);

    // 1: first key, enable once the synchronizer holds the pin value
    kif.ui_in = AUTH_KEY;
    rst_n = 1'b1;
    first = -1; n = strobes;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == S - 1) kif.ena = 1'b1;
      if (kif.key_valid === 1'b1 && first < 0) first = e;
    end
    chk("t1_strobe_edge", first, S + D - 1);
    chk("t1_strobe_cnt", strobes - n, 1);
    chk("t1_key", kif.key_out, AUTH_KEY);
    chk("t1_glitch", kif.glitch_cnt, 0);

    // 2: one-cycle dither away and back
    n = strobes;
    kif.ui_in = 8'h12; step();
    kif.ui_in = AUTH_KEY;
    for (int e = 0; e < 10; e++) step();
    chk("t2_strobe_cnt", strobes - n, 1);
    chk("t2_key", kif.key_out, AUTH_KEY);

    // 3: freeze across the due strobe edge
    kif.ui_in = 8'h5A;
    hit = 0;
    for (int e = 0; e < 20 && !hit; e++) begin
      step();
      hit = (m_run_val == 8'h5A && m_run_len == D - 1 && !m_acc);
    end
    chk("t3_reach", hit, 1);
    n = strobes;
    kif.ena = 1'b0;
    for (int e = 0; e < 3; e++) step();
    chk("t3_frozen", strobes - n, 0);
    kif.ena = 1'b1;
    first = -1;
    for (int e = 0; e < 6; e++) begin
      step();
      if (kif.key_valid === 1'b1 && first < 0) first = e;
    end
    chk("t3_deferred_edge", first, 0);
    chk("t3_strobe_cnt", strobes - n, 1);
    chk("t3_key", kif.key_out, 8'h5A);

    // 4: async reset in the middle of a settle
    kif.ui_in = AUTH_KEY;
    hit = 0;
    for (int e = 0; e < 20 && !hit; e++) begin
      step();
      hit = (m_run_val == AUTH_KEY && m_run_len == 2 && !m_acc);
    end
    chk("t4_reach", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_key_out", kif.key_out, 8'h00);
    chk("t4_valid", kif.key_valid, 1'b0);
    chk("t4_stable", kif.key_stable, 1'b0);
    chk("t4_glitch", kif.glitch_cnt, 8'h00);
    model_reset();
    step(); step();
    #2 rst_n = 1'b1;
    n = strobes; first = -1;
    for (int e = 0; e < 12; e++) begin
      step();
      if (kif.key_valid === 1'b1 && first < 0) first = e;
    end
    chk("t4_resettle_edge", first, S + D - 1);
    chk("t4_strobe_cnt", strobes - n, 1);

    // 5: continuous dither saturates the glitch counter
    n = strobes;
    for (int e = 0; e < 300; e++) begin
      kif.ui_in = kif.ui_in ^ 8'($urandom_range(1, 255));
      step();
    end
    chk("t5_glitch_sat", kif.glitch_cnt, 8'hFF);
    chk("t5_no_strobe", strobes - n, 0);
    chk("t5_stable", kif.key_stable, 1'b0);

    // random segments with occasional freezes and repeated bytes
    v = 8'h00;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 3) != 0) v = 8'($urandom);
      kif.ui_in = v;
      n = $urandom_range(1, 8);
      for (int e = 0; e < n; e++) begin
        kif.ena = ($urandom_range(0, 5) != 0);
        step();
      end
    end
    kif.ena = 1'b1;
    for (int e = 0; e < 10; e++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
